mem_bus_responder: RTL and testbench

//  Target end of the CPU memory bus: the CPU initiates; this block answers.
//  - Decodes addr_bus, sequences the one-cycle-latency block RAMs (boot ROM, work RAM) and drives the tri-state data_bus.
//  - Returns mem_rdy to finish each transfer. Sits beside cpu_top at system top, replacing ad-hoc glue.

---
 rtl/bus_map_pkg.sv | 19 +
 rtl/mem_bus_responder_if.sv | 10 +
 rtl/bus_addr_decode.sv | 19 +
 rtl/mem_bus_responder.sv | 123 ++++++++++++
 tb/tb_mem_bus_responder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_map_pkg.sv
// bus_map_pkg: CPU bus memory map, decode regions and responder FSM states.
// HRAM_EN follows the BUS_HRAM_EN build macro.
package bus_map_pkg;
    localparam logic [15:0] ROM_BASE      = 16'h0000;
    localparam logic [15:0] WRAM_BASE     = 16'hC000;
    localparam logic [15:0] ECHO_BASE     = 16'hE000;
    localparam logic [15:0] ECHO_LIMIT    = 16'hFDFF;
    localparam logic [15:0] BOOT_OFF_ADDR = 16'hFF50;
    localparam logic [15:0] HRAM_BASE     = 16'hFF80;
    localparam logic [15:0] HRAM_LIMIT    = 16'hFFFE;
    localparam int          HRAM_DEPTH    = 127;
`ifdef BUS_HRAM_EN
    localparam bit HRAM_EN = 1'b1;
`else
    localparam bit HRAM_EN = 1'b0;
`endif
    typedef enum logic [2:0] {REG_ROM, REG_WRAM, REG_BOOTREG, REG_HRAM, REG_NONE} region_t;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR_DONE} state_t;
endpackage

// File: rtl/mem_bus_responder_if.sv
// mem_bus_responder_if: CPU memory-bus request/handshake signals (data bus is a separate tri-state port).
interface mem_bus_responder_if;
    logic [15:0] addr_bus;
    logic        mem_cs;
    logic        mem_oe;
    logic        mem_wr;
    logic        mem_rdy;
    modport master (output addr_bus, mem_cs, mem_oe, mem_wr, input mem_rdy);
    modport slave  (input addr_bus, mem_cs, mem_oe, mem_wr, output mem_rdy);
endinterface

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: combinational CPU address -> region and local offset (HRAM only with BUS_HRAM_EN).
module bus_addr_decode
    import bus_map_pkg::*;
(
    input  logic [15:0] i_addr,
    input  logic        i_boot_off,
    output region_t     o_region,
    output logic [12:0] o_offset
);
    logic w_rom, w_wram, w_echo, w_boot, w_hram;
    assign w_rom    = (i_addr[15:8] == ROM_BASE[15:8]) && !i_boot_off;
    assign w_wram   = (i_addr >= WRAM_BASE) && (i_addr < ECHO_BASE);
    assign w_echo   = (i_addr >= ECHO_BASE) && (i_addr <= ECHO_LIMIT);
    assign w_boot   = i_addr == BOOT_OFF_ADDR;
    assign w_hram   = HRAM_EN && (i_addr >= HRAM_BASE) && (i_addr <= HRAM_LIMIT);
    assign o_region = w_rom ? REG_ROM : (w_wram || w_echo) ? REG_WRAM : w_boot ? REG_BOOTREG :
                      w_hram ? REG_HRAM : REG_NONE;
    assign o_offset = i_addr[12:0];
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: CPU memory-bus target; sequences boot ROM/WRAM and drives the tri-state data bus.
// Build macro BUS_HRAM_EN adds a 127-byte register-file HRAM at 0xFF80-0xFFFE.
module mem_bus_responder
    import bus_map_pkg::*;
#(
    parameter int          ROM_AW       = 8,
    parameter int          WRAM_AW      = 13,
    parameter logic [7:0]  UNMAPPED_VAL = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_responder_if.slave bus,
    inout  wire  [7:0]         io_data_bus,
    output logic [ROM_AW-1:0]  o_rom_addr,
    input  logic [7:0]         i_rom_dout,
    output logic               o_wram_en,
    output logic               o_wram_we,
    output logic [WRAM_AW-1:0] o_wram_addr,
    output logic [7:0]         o_wram_din,
    input  logic [7:0]         i_wram_dout,
    output logic               o_boot_off,
    output logic               o_bus_err
);
    region_t            w_region;
    logic [12:0]        w_offset;
    logic [7:0]         w_aux_q;
    logic               w_drive;
    state_t             r_state;
    region_t            r_region;
    logic               r_lat, r_rdy, r_wram_en, r_wram_we, r_boot_off, r_bus_err;
    logic [ROM_AW-1:0]  r_rom_addr;
    logic [WRAM_AW-1:0] r_wram_addr;
    logic [7:0]         r_wram_din, r_rd_q;

    bus_addr_decode u_dec (
        .i_addr     (bus.addr_bus),
        .i_boot_off (r_boot_off),
        .o_region   (w_region),
        .o_offset   (w_offset)
    );

`ifdef BUS_HRAM_EN
    logic [7:0] r_hram [HRAM_DEPTH];
    logic [6:0] r_hram_idx;
    always_ff @(posedge clk) begin
        if (!rst && r_state == IDLE && bus.mem_cs && bus.mem_wr && !bus.mem_oe && w_region == REG_HRAM)
            r_hram[w_offset[6:0]] <= io_data_bus;
        if (r_state == IDLE)
            r_hram_idx <= w_offset[6:0];
    end
    assign w_aux_q = (r_region == REG_HRAM) ? r_hram[r_hram_idx] : UNMAPPED_VAL;
`else
    assign w_aux_q = UNMAPPED_VAL;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_region    <= REG_NONE;
            r_lat       <= 1'b0;
            r_rdy       <= 1'b0;
            r_wram_en   <= 1'b0;
            r_wram_we   <= 1'b0;
            r_boot_off  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_rom_addr  <= '0;
            r_wram_addr <= '0;
            r_wram_din  <= '0;
            r_rd_q      <= '0;
        end else begin
            r_wram_en <= 1'b0;
            r_wram_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.mem_cs && (bus.mem_oe || bus.mem_wr)) begin
                        r_region    <= w_region;
                        r_rom_addr  <= w_offset[ROM_AW-1:0];
                        r_wram_addr <= w_offset[WRAM_AW-1:0];
                        r_wram_en   <= w_region == REG_WRAM;
                    end
                    if (bus.mem_cs && bus.mem_oe) begin
                        r_bus_err <= r_bus_err | bus.mem_wr;
                        r_lat     <= 1'b0;
                        r_state   <= RD_WAIT;
                    end else if (bus.mem_cs && bus.mem_wr) begin
                        r_wram_we  <= w_region == REG_WRAM;
                        r_wram_din <= io_data_bus;
                        r_boot_off <= r_boot_off | (w_region == REG_BOOTREG && io_data_bus != 8'h00);
                        r_rdy      <= 1'b1;
                        r_state    <= WR_DONE;
                    end
                end
                RD_WAIT: begin
                    // first cycle lets the block RAM clock the registered address
                    r_lat <= 1'b1;
                    if (r_lat) begin
                        r_rd_q  <= (r_region == REG_ROM) ? i_rom_dout :
                                   (r_region == REG_WRAM) ? i_wram_dout : w_aux_q;
                        r_rdy   <= 1'b1;
                        r_state <= RD_DONE;
                    end
                end
                default: begin
                    if (!bus.mem_cs) begin
                        r_rdy   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign w_drive     = (r_state == RD_DONE) && bus.mem_cs;
    assign io_data_bus = w_drive ? r_rd_q : 8'hzz;
    assign bus.mem_rdy = r_rdy;
    assign o_rom_addr  = r_rom_addr;
    assign o_wram_en   = r_wram_en;
    assign o_wram_we   = r_wram_we;
    assign o_wram_addr = r_wram_addr;
    assign o_wram_din  = r_wram_din;
    assign o_boot_off  = r_boot_off;
    assign o_bus_err   = r_bus_err;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: table-driven bench for mem_bus_responder with behavioural ROM/WRAM.
// HRAM expectations follow the BUS_HRAM_EN build macro.
module tb_mem_bus_responder;
    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [7:0]  v;
        string       n;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tb_drv = 1'b1;
    logic [7:0]  tb_d = 8'h3C;
    wire  [7:0]  data_bus;
    logic [7:0]  rom_addr, rom_dout, wram_din, wram_dout;
    logic [12:0] wram_addr;
    logic        wram_en, wram_we, boot_off, bus_err;
    logic [7:0]  rom [256];
    logic [7:0]  wram [8192];
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl [19];

    mem_bus_responder_if bus_if ();

    mem_bus_responder dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .io_data_bus (data_bus),
        .o_rom_addr  (rom_addr),
        .i_rom_dout  (rom_dout),
        .o_wram_en   (wram_en),
        .o_wram_we   (wram_we),
        .o_wram_addr (wram_addr),
        .o_wram_din  (wram_din),
        .i_wram_dout (wram_dout),
        .o_boot_off  (boot_off),
        .o_bus_err   (bus_err)
    );

    assign data_bus = tb_drv ? tb_d : 8'hzz;
    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom[rom_addr];
    always @(posedge clk) begin
        if (wram_en) begin
            if (wram_we) wram[wram_addr] <= wram_din;
            wram_dout <= wram[wram_addr];
        end
    end

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            if (bus_if.mem_rdy) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic finish_rd();
        bus_if.mem_cs = 1'b0;
        bus_if.mem_oe = 1'b0;
        bus_if.mem_wr = 1'b0;
        tb_drv = 1'b1;
        tb_d = 8'h3C;
        #1 chk("release", {8'h00, data_bus}, 16'h003C);
        @(negedge clk);
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] alt, input logic both,
                      output logic [7:0] d, output int lat);
        tb_drv = 1'b0;
        bus_if.addr_bus = a;
        bus_if.mem_oe = 1'b1;
        bus_if.mem_wr = both;
        bus_if.mem_cs = 1'b1;
        @(posedge clk);
        #1 bus_if.addr_bus = alt;
        wait_rdy(lat);
        d = data_bus;
        finish_rd();
    endtask

    task automatic wrt(input logic [15:0] a, input logic [7:0] v, output int lat);
        tb_drv = 1'b1;
        tb_d = v;
        bus_if.addr_bus = a;
        bus_if.mem_oe = 1'b0;
        bus_if.mem_wr = 1'b1;
        bus_if.mem_cs = 1'b1;
        @(posedge clk);
        wait_rdy(lat);
        bus_if.mem_cs = 1'b0;
        bus_if.mem_wr = 1'b0;
        tb_d = 8'h3C;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         lat;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i * 3 + 8'h31);
        tbl = '{
            '{1'b0, 16'h0000, 8'h31, "rom0"},
            '{1'b0, 16'h0001, 8'h34, "rom1"},
            '{1'b0, 16'h00FF, 8'h2E, "rom_top"},
            '{1'b0, 16'h0100, 8'hFF, "rom_past"},
            '{1'b1, 16'hC123, 8'hA5, "wr_c123"},
            '{1'b0, 16'hC123, 8'hA5, "wram_rd"},
            '{1'b1, 16'hE010, 8'h5A, "wr_echo"},
            '{1'b0, 16'hC010, 8'h5A, "echo_rd"},
            '{1'b0, 16'hE123, 8'hA5, "echo_alias"},
            '{1'b1, 16'hFDFF, 8'h22, "wr_echo_top"},
            '{1'b0, 16'hDDFF, 8'h22, "echo_top"},
            '{1'b0, 16'hFE00, 8'hFF, "past_echo"},
            '{1'b0, 16'hBFFF, 8'hFF, "below_wram"},
            '{1'b1, 16'h8000, 8'h99, "wr_unmapped"},
            '{1'b0, 16'h8000, 8'hFF, "unmapped"},
            '{1'b1, 16'hFF50, 8'h00, "wr_boot0"},
            '{1'b0, 16'h0000, 8'h31, "rom_still"},
            '{1'b0, 16'hFF50, 8'hFF, "bootreg_wo"},
            '{1'b0, 16'hFFFF, 8'hFF, "ffff"}
        };
        bus_if.addr_bus = 16'h0000;
        bus_if.mem_cs = 1'b0;
        bus_if.mem_oe = 1'b0;
        bus_if.mem_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {15'h0, bus_if.mem_rdy}, 16'h0);
        chk("rst_wram_en", {15'h0, wram_en}, 16'h0);
        chk("rst_wram_we", {15'h0, wram_we}, 16'h0);
        chk("rst_boot_off", {15'h0, boot_off}, 16'h0);
        chk("rst_bus_err", {15'h0, bus_err}, 16'h0);
        chk("rst_rom_addr", {8'h0, rom_addr}, 16'h0);
        chk("rst_wram_addr", {3'h0, wram_addr}, 16'h0);
        chk("rst_wram_din", {8'h0, wram_din}, 16'h0);
        chk("rst_bus_z", {8'h0, data_bus}, 16'h003C);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 19; k++) begin
            if (tbl[k].wr) begin
                wrt(tbl[k].a, tbl[k].v, lat);
                chk({tbl[k].n, "_lat"}, 16'(lat), 16'd0);
            end else begin
                rd(tbl[k].a, tbl[k].a, 1'b0, d, lat);
                chk(tbl[k].n, {8'h0, d}, {8'h0, tbl[k].v});
                chk({tbl[k].n, "_lat"}, 16'(lat), 16'd2);
            end
        end

        // single-cycle write strobe while cs is still held
        tb_d = 8'hB6;
        bus_if.addr_bus = 16'hC124;
        bus_if.mem_wr = 1'b1;
        bus_if.mem_cs = 1'b1;
        @(negedge clk);
        chk("wp_rdy", {15'h0, bus_if.mem_rdy}, 16'h1);
        chk("wp_en", {15'h0, wram_en}, 16'h1);
        chk("wp_we", {15'h0, wram_we}, 16'h1);
        chk("wp_addr", {3'h0, wram_addr}, 16'h0124);
        chk("wp_din", {8'h0, wram_din}, 16'h00B6);
        @(negedge clk);
        chk("wp_we_drop", {15'h0, wram_we}, 16'h0);
        chk("wp_rdy_hold", {15'h0, bus_if.mem_rdy}, 16'h1);
        bus_if.mem_cs = 1'b0;
        bus_if.mem_wr = 1'b0;
        tb_d = 8'h3C;
        @(negedge clk);
        chk("wp_rdy_low", {15'h0, bus_if.mem_rdy}, 16'h0);
        rd(16'hC124, 16'hC124, 1'b0, d, lat);
        chk("wp_readback", {8'h0, d}, 16'h00B6);

        bus_if.addr_bus = 16'hC124;
        bus_if.mem_cs = 1'b1;
        repeat (3) @(negedge clk);
        chk("nostrobe_rdy", {15'h0, bus_if.mem_rdy}, 16'h0);
        chk("nostrobe_en", {15'h0, wram_en}, 16'h0);
        bus_if.mem_cs = 1'b0;
        @(negedge clk);

        rd(16'hC123, 16'h0000, 1'b0, d, lat);
        chk("addr_change", {8'h0, d}, 16'h00A5);

        wrt(16'hFF50, 8'h01, lat);
        chk("boot_set", {15'h0, boot_off}, 16'h1);
        rd(16'h0000, 16'h0000, 1'b0, d, lat);
        chk("boot_rom_gone", {8'h0, d}, 16'h00FF);
        wrt(16'hFF50, 8'h00, lat);
        chk("boot_sticky", {15'h0, boot_off}, 16'h1);

        wrt(16'hFF80, 8'h77, lat);
        rd(16'hFF80, 16'hFF80, 1'b0, d, lat);
`ifdef BUS_HRAM_EN
        chk("hram_lo", {8'h0, d}, 16'h0077);
`else
        chk("hram_lo", {8'h0, d}, 16'h00FF);
`endif
        chk("hram_lat", 16'(lat), 16'd2);
        wrt(16'hFFFE, 8'h12, lat);
        rd(16'hFFFE, 16'hFFFE, 1'b0, d, lat);
`ifdef BUS_HRAM_EN
        chk("hram_hi", {8'h0, d}, 16'h0012);
`else
        chk("hram_hi", {8'h0, d}, 16'h00FF);
`endif

        wrt(16'hC000, 8'h42, lat);
        chk("err_clear", {15'h0, bus_err}, 16'h0);
        rd(16'hC000, 16'hC000, 1'b1, d, lat);
        chk("err_read", {8'h0, d}, 16'h0042);
        chk("err_lat", 16'(lat), 16'd2);
        chk("err_set", {15'h0, bus_err}, 16'h1);

        // reset while in RD_WAIT, then cs held across reset release
        tb_drv = 1'b0;
        bus_if.addr_bus = 16'hC123;
        bus_if.mem_oe = 1'b1;
        bus_if.mem_cs = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_rdy", {15'h0, bus_if.mem_rdy}, 16'h0);
        chk("mrst_err", {15'h0, bus_err}, 16'h0);
        chk("mrst_boot", {15'h0, boot_off}, 16'h0);
        tb_drv = 1'b1;
        #1 chk("mrst_bus_z", {8'h0, data_bus}, 16'h003C);
        tb_drv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        wait_rdy(lat);
        chk("held_lat", 16'(lat), 16'd2);
        chk("held_data", {8'h0, data_bus}, 16'h00A5);
        finish_rd();
        rd(16'h0000, 16'h0000, 1'b0, d, lat);
        chk("rom_back", {8'h0, d}, 16'h0031);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
